game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
Central game controller for the whack-a-mole design. It sequences the game through the phases idle, 5 s pre-game countdown, 30 s play and game over. During play it schedules mole LEDs from the random source, detects hits from debounced buttons and keeps the score. It drives the value shown on the seven-segment path, so the display mux and stand-alone begin-control logic are no longer needed.

Parameters:
COUNTDOWN_SEC, 5, length of the pre-game countdown in seconds (1..255)
GAME_SEC, 30, length of the play phase in seconds (1..255)
N_MOLES, 5, number of mole LEDs / buttons

Ports:
clk  input  1  system clock, 100 MHz; the only clock
reset  input  1  asynchronous, active-low reset
sec_tick  input  1  one-clk-wide pulse once per second, synchronous to clk
start_btn  input  1  debounced start button, level
button_db  input  N_MOLES  debounced mole buttons, level, 1 = pressed
rand_in  input  N_MOLES  pseudo-random mole pattern, sampled on sec_tick
led_out  output  N_MOLES  mole LEDs currently lit
score  output  8  hit count of the current or last game
time_left  output  8  seconds remaining in the current phase
disp_value  output  8  value for the display path
phase  output  2  0=IDLE, 1=COUNTDOWN, 2=PLAY, 3=DONE
game_over  output  1  high while in DONE

Behaviour:
- Reset (reset=0, asynchronous) forces the following:
  - state IDLE; led_out, score, time_left, disp_value all 0; game_over 0.
  - Edge-detect registers for start_btn and button_db preset to all-ones, so a button held through reset is not a press.
- Press detection: press = level & ~prev_level, registered each clk. A press is one clk wide. Holding a button gives exactly one press.
- IDLE:
  - On a start press: go to COUNTDOWN, time_left=COUNTDOWN_SEC, score=0. The transition takes effect on the next clk edge.
- COUNTDOWN:
  - On sec_tick with time_left>1: decrement time_left.
  - On sec_tick with time_left==1: go to PLAY, time_left=GAME_SEC, led_out=rand_in.
  - Start and mole presses are ignored; led_out stays 0.
- PLAY:
  - On sec_tick with time_left>1: decrement time_left and load led_out=rand_in (new moles replace old ones).
  - On sec_tick with time_left==1: go to DONE, time_left=0, led_out=0.
  - Hit: if (press & led_out) != 0, score increments by exactly 1 and every hit bit is cleared in led_out. Multiple simultaneous hits still count as +1.
  - Press on an unlit position: no effect, no penalty.
  - score saturates at 255.
  - Hit and sec_tick in the same cycle: the hit is scored against the old led_out. The new pattern is loaded unmasked, and the tick/terminal rule applies as usual. On the final tick the hit still counts.
  - Start presses are ignored.
- DONE:
  - game_over=1; score holds; led_out=0.
  - On a start press: go to COUNTDOWN, time_left=COUNTDOWN_SEC, score=0, game_over=0.
- disp_value is registered and follows the state of the same cycle:
  - IDLE: 0.
  - COUNTDOWN: time_left.
  - PLAY and DONE: score.
- phase and game_over are decoded from the state register with no extra latency. All other outputs are registered.
- sec_tick arriving in the same cycle as the start press in IDLE is ignored. The countdown starts on the next tick.
- An illegal state encoding recovers to IDLE with all outputs cleared.
- Reset asserted mid-game aborts immediately to IDLE; score is lost.

Test Plan:
1. Release reset with start_btn held high, pulse sec_tick 3 times -> phase stays 0, disp_value 0; release then press start -> phase 1, time_left 5.
2. Start, apply 5 sec_ticks with rand_in=5'b10010 -> time_left 5,4,3,2,1, then phase 2, time_left 30, led_out 10010, disp_value 0.
3. In PLAY with led_out=10010, press bit 1 -> score 1, led_out 10000; hold bit 1 for 100 clk -> score stays 1; press bit 0 -> score stays 1.
4. Press bits 4 and 1 in the same cycle as sec_tick, rand_in=01100 -> score +1, led_out 01100, time_left decrements by 1.
5. Run 30 play ticks with one hit per tick -> after the final tick phase 3, game_over 1, score 30, led_out 0; then press start -> phase 1, score 0, time_left 5.
6. Force score to 255 via repeated hits, then hit again -> score stays 255. Assert reset mid-PLAY -> all outputs 0 immediately, phase 0.

Source files
------------

// File: rtl/game_sequencer.sv
// Whack-a-mole game controller: idle, countdown, play and done phases.
// In: sec_tick, start_btn, button_db, rand_in. Out: led_out, score, time_left, disp_value, phase, game_over.
module game_sequencer #(
    parameter int COUNTDOWN_SEC = 5,
    parameter int GAME_SEC      = 30,
    parameter int N_MOLES       = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sec_tick,
    input  logic               start_btn,
    input  logic [N_MOLES-1:0] button_db,
    input  logic [N_MOLES-1:0] rand_in,
    output logic [N_MOLES-1:0] led_out,
    output logic [7:0]         score,
    output logic [7:0]         time_left,
    output logic [7:0]         disp_value,
    output logic [1:0]         phase,
    output logic               game_over
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        PLAY      = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [7:0] CD_LEN   = 8'(COUNTDOWN_SEC);
    localparam logic [7:0] GAME_LEN = 8'(GAME_SEC);

    state_t             state;
    logic               start_prev;
    logic               start_press;
    logic [N_MOLES-1:0] btn_prev;
    logic [N_MOLES-1:0] btn_press;
    logic               hit;
    logic [7:0]         score_nxt;

    // Previous levels preset to ones so a button held through reset
    // is not seen as a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_prev  <= 1'b1;
            start_press <= 1'b0;
            btn_prev    <= '1;
            btn_press   <= '0;
        end else begin
            start_prev  <= start_btn;
            start_press <= start_btn & ~start_prev;
            btn_prev    <= button_db;
            btn_press   <= button_db & ~btn_prev;
        end
    end

    // Any number of simultaneous hits scores one point; saturate at 255.
    always_comb begin
        hit       = |(btn_press & led_out);
        score_nxt = score;
        if (hit && score != 8'hFF)
            score_nxt = score + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            led_out    <= '0;
            score      <= 8'd0;
            time_left  <= 8'd0;
            disp_value <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    led_out    <= '0;
                    disp_value <= 8'd0;
                    if (start_press) begin
                        state      <= COUNTDOWN;
                        time_left  <= CD_LEN;
                        score      <= 8'd0;
                        disp_value <= CD_LEN;
                    end
                end
                COUNTDOWN: begin
                    led_out    <= '0;
                    disp_value <= time_left;
                    if (sec_tick) begin
                        if (time_left > 8'd1) begin
                            time_left  <= time_left - 8'd1;
                            disp_value <= time_left - 8'd1;
                        end else begin
                            state      <= PLAY;
                            time_left  <= GAME_LEN;
                            led_out    <= rand_in;
                            disp_value <= score;
                        end
                    end
                end
                PLAY: begin
                    // A hit coinciding with a tick is scored against the
                    // old pattern; the new pattern loads unmasked.
                    score      <= score_nxt;
                    disp_value <= score_nxt;
                    if (sec_tick) begin
                        if (time_left > 8'd1) begin
                            time_left <= time_left - 8'd1;
                            led_out   <= rand_in;
                        end else begin
                            state     <= DONE;
                            time_left <= 8'd0;
                            led_out   <= '0;
                        end
                    end else begin
                        led_out <= led_out & ~btn_press;
                    end
                end
                DONE: begin
                    led_out    <= '0;
                    disp_value <= score;
                    if (start_press) begin
                        state      <= COUNTDOWN;
                        time_left  <= CD_LEN;
                        score      <= 8'd0;
                        disp_value <= CD_LEN;
                    end
                end
                default: begin
                    state      <= IDLE;
                    led_out    <= '0;
                    score      <= 8'd0;
                    time_left  <= 8'd0;
                    disp_value <= 8'd0;
                end
            endcase
        end
    end

    assign phase     = state;
    assign game_over = (state == DONE);

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: default instance plus a
// long-game instance used to reach score saturation.
module tb_game_sequencer;

    logic       clk;
    logic       reset;
    logic       sec_tick;
    logic       start_btn;
    logic [4:0] button_db;
    logic [4:0] rand_in;
    logic [4:0] led_out;
    logic [7:0] score;
    logic [7:0] time_left;
    logic [7:0] disp_value;
    logic [1:0] phase;
    logic       game_over;

    logic       s_tick;
    logic       s_start;
    logic [4:0] s_btn;
    logic [4:0] s_rand;
    logic [4:0] s_led;
    logic [7:0] s_score;
    logic [7:0] s_time;
    logic [7:0] s_disp;
    logic [1:0] s_phase;
    logic       s_over;

    int n_cmp = 0;
    int n_err = 0;

    game_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .sec_tick   (sec_tick),
        .start_btn  (start_btn),
        .button_db  (button_db),
        .rand_in    (rand_in),
        .led_out    (led_out),
        .score      (score),
        .time_left  (time_left),
        .disp_value (disp_value),
        .phase      (phase),
        .game_over  (game_over)
    );

    game_sequencer #(.GAME_SEC(60)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .sec_tick   (s_tick),
        .start_btn  (s_start),
        .button_db  (s_btn),
        .rand_in    (s_rand),
        .led_out    (s_led),
        .score      (s_score),
        .time_left  (s_time),
        .disp_value (s_disp),
        .phase      (s_phase),
        .game_over  (s_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        step(1);
        sec_tick = 1'b0;
    endtask

    task automatic s_tick_pulse();
        s_tick = 1'b1;
        step(1);
        s_tick = 1'b0;
    endtask

    task automatic hit(input logic [4:0] b);
        button_db = b;
        step(2);
        button_db = 5'b0;
        step(1);
    endtask

    task automatic s_hit(input logic [4:0] b);
        s_btn = b;
        step(2);
        s_btn = 5'b0;
        step(1);
    endtask

    initial begin
        reset     = 1'b0;
        sec_tick  = 1'b0;
        start_btn = 1'b1;
        button_db = 5'b0;
        rand_in   = 5'b0;
        s_tick    = 1'b0;
        s_start   = 1'b0;
        s_btn     = 5'b0;
        s_rand    = 5'b11111;
        step(3);
        check("rst_phase", phase, 2'd0);
        check("rst_led", led_out, 5'b0);
        check("rst_score", score, 8'd0);
        check("rst_time", time_left, 8'd0);
        check("rst_disp", disp_value, 8'd0);
        check("rst_over", game_over, 1'b0);

        // start held through reset is not a press
        reset = 1'b1;
        step(2);
        repeat (3) begin
            tick();
            step(1);
        end
        check("held_phase", phase, 2'd0);
        check("held_disp", disp_value, 8'd0);
        start_btn = 1'b0;
        step(2);
        start_btn = 1'b1;
        step(2);
        check("start_phase", phase, 2'd1);
        check("start_time", time_left, 8'd5);
        check("start_disp", disp_value, 8'd5);
        start_btn = 1'b0;

        // countdown
        rand_in = 5'b10010;
        for (int i = 4; i >= 1; i--) begin
            tick();
            check("cd_time", time_left, 32'(i));
            check("cd_disp", disp_value, 32'(i));
        end
        tick();
        check("play_phase", phase, 2'd2);
        check("play_time", time_left, 8'd30);
        check("play_led", led_out, 5'b10010);
        check("play_disp", disp_value, 8'd0);

        // hit, hold, unlit press
        button_db = 5'b00010;
        step(2);
        check("hit_score", score, 8'd1);
        check("hit_led", led_out, 5'b10000);
        check("hit_disp", disp_value, 8'd1);
        step(100);
        check("hold_score", score, 8'd1);
        button_db = 5'b0;
        step(2);
        button_db = 5'b00001;
        step(2);
        check("unlit_score", score, 8'd1);
        check("unlit_led", led_out, 5'b10000);
        button_db = 5'b0;
        step(2);

        // hit on bits 4 and 1 together with a tick (only bit 4 lit)
        button_db = 5'b10010;
        step(1);
        rand_in = 5'b01100;
        tick();
        check("tk_score", score, 8'd2);
        check("tk_led", led_out, 5'b01100);
        check("tk_time", time_left, 8'd29);
        button_db = 5'b0;
        step(2);

        // 28 ticks each preceded by a hit, then a hit on the final tick
        rand_in = 5'b00100;
        for (int i = 0; i < 28; i++) begin
            hit(5'b00100);
            tick();
        end
        check("pre_end_time", time_left, 8'd1);
        check("pre_end_score", score, 8'd30);
        button_db = 5'b00100;
        step(1);
        tick();
        button_db = 5'b0;
        check("end_phase", phase, 2'd3);
        check("end_over", game_over, 1'b1);
        check("end_score", score, 8'd31);
        check("end_led", led_out, 5'b0);
        check("end_time", time_left, 8'd0);
        check("end_disp", disp_value, 8'd31);
        step(3);
        check("done_hold", score, 8'd31);

        // restart from DONE
        start_btn = 1'b1;
        step(2);
        start_btn = 1'b0;
        check("re_phase", phase, 2'd1);
        check("re_score", score, 8'd0);
        check("re_time", time_left, 8'd5);
        check("re_over", game_over, 1'b0);
        button_db = 5'b11111;
        step(2);
        button_db = 5'b0;
        check("cd_ign_led", led_out, 5'b0);
        check("cd_ign_score", score, 8'd0);

        // saturation on the long-game instance
        step(1);
        s_start = 1'b1;
        step(2);
        s_start = 1'b0;
        check("s_phase", s_phase, 2'd1);
        repeat (5) s_tick_pulse();
        check("s_play", s_phase, 2'd2);
        for (int j = 0; j < 51; j++) begin
            for (int b = 0; b < 5; b++)
                s_hit(5'(1 << b));
            s_tick_pulse();
            if (j == 49)
                check("s_250", s_score, 8'd250);
        end
        check("s_255", s_score, 8'd255);
        check("s_time", s_time, 8'd9);
        s_hit(5'b00001);
        check("s_sat", s_score, 8'd255);
        check("s_sat_disp", s_disp, 8'd255);
        check("s_sat_led", s_led, 5'b11110);

        // reset mid-PLAY on the default instance
        repeat (5) tick();
        check("p2_phase", phase, 2'd2);
        hit(5'b00100);
        check("p2_score", score, 8'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_phase", phase, 2'd0);
        check("mid_score", score, 8'd0);
        check("mid_led", led_out, 5'b0);
        check("mid_time", time_left, 8'd0);
        check("mid_disp", disp_value, 8'd0);
        check("mid_over", game_over, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
